// File: rtl/bcd_calc_pkg.sv
// Shared constants, state encoding and BCD helpers for the two-digit BCD calculator.
// Key codes 14 and 15 are reserved and have no named constant here.
package bcd_calc_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_ADD = 4'd10;
  localparam logic [DIGIT_W-1:0] KEY_SUB = 4'd11;
  localparam logic [DIGIT_W-1:0] KEY_EQ  = 4'd12;
  localparam logic [DIGIT_W-1:0] KEY_CLR = 4'd13;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    SHOW    = 3'd3,
    ERROR   = 3'd4
  } state_e;

  // Two BCD digits to a binary value in the range 0..99.
  function automatic logic [7:0] bcd_to_bin(input logic [DIGIT_W-1:0] tens,
                                            input logic [DIGIT_W-1:0] ones);
    return ({4'd0, tens} * 8'd10) + {4'd0, ones};
  endfunction

endpackage

// File: rtl/bcd_addsub_2digit.sv
// Combinational two-digit BCD add/subtract with an out-of-range flag.
// An out-of-range result is forced to 00 so the controller can register it directly.
module bcd_addsub_2digit
  import bcd_calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_tens_i,
  input  logic [DIGIT_W-1:0] a_ones_i,
  input  logic [DIGIT_W-1:0] b_tens_i,
  input  logic [DIGIT_W-1:0] b_ones_i,
  input  logic               sub_i,
  output logic [DIGIT_W-1:0] res_tens_o,
  output logic [DIGIT_W-1:0] res_ones_o,
  output logic               range_err_o
);

  logic [7:0] a_bin;
  logic [7:0] b_bin;
  logic [7:0] raw;

  always_comb begin
    a_bin       = bcd_to_bin(a_tens_i, a_ones_i);
    b_bin       = bcd_to_bin(b_tens_i, b_ones_i);
    raw         = 8'd0;
    range_err_o = 1'b0;
    if (sub_i) begin
      range_err_o = (b_bin > a_bin);
      raw         = a_bin - b_bin;
    end else begin
      raw         = a_bin + b_bin;
      range_err_o = (raw > 8'd99);
    end
    if (range_err_o) begin
      raw = 8'd0;
    end
    res_tens_o = 4'(raw / 8'd10);
    res_ones_o = 4'(raw % 8'd10);
  end

endmodule

// File: rtl/bcd_calc_controller.sv
// Keypad-driven controller for the two-digit BCD calculator: operand entry,
// one-cycle execute, result display, error recovery and optional result chaining.
module bcd_calc_controller
  import bcd_calc_pkg::*;
#(
  parameter logic CHAIN_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  output logic               key_ready,
  output logic [DIGIT_W-1:0] a_tens,
  output logic [DIGIT_W-1:0] a_ones,
  output logic [DIGIT_W-1:0] b_tens,
  output logic [DIGIT_W-1:0] b_ones,
  output logic               op_sub,
  output logic [DIGIT_W-1:0] res_tens,
  output logic [DIGIT_W-1:0] res_ones,
  output logic               res_valid,
  output logic               err,
  output logic [2:0]         state_o
);

  state_e             state_q;
  logic [DIGIT_W-1:0] a_tens_q, a_ones_q, b_tens_q, b_ones_q;
  logic [DIGIT_W-1:0] res_tens_q, res_ones_q;
  logic               op_sub_q, res_valid_q, err_q, key_ready_q;

  logic [DIGIT_W-1:0] res_tens_d, res_ones_d;
  logic               err_d;

  logic accept, is_digit, is_op;

  assign accept   = key_valid && key_ready_q;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);

  bcd_addsub_2digit u_addsub (
    .a_tens_i   (a_tens_q),
    .a_ones_i   (a_ones_q),
    .b_tens_i   (b_tens_q),
    .b_ones_i   (b_ones_q),
    .sub_i      (op_sub_q),
    .res_tens_o (res_tens_d),
    .res_ones_o (res_ones_d),
    .range_err_o(err_d)
  );

  // key_ready drops only while the registered operands settle through the unit (EXEC).
  always_ff @(posedge clk) begin
    if (rst || (accept && key_code == KEY_CLR)) begin
      state_q     <= ENTER_A;
      a_tens_q    <= '0;
      a_ones_q    <= '0;
      b_tens_q    <= '0;
      b_ones_q    <= '0;
      res_tens_q  <= '0;
      res_ones_q  <= '0;
      op_sub_q    <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (accept && is_digit) begin
            a_tens_q <= a_ones_q;
            a_ones_q <= key_code;
          end else if (accept && is_op) begin
            op_sub_q <= (key_code == KEY_SUB);
            b_tens_q <= '0;
            b_ones_q <= '0;
            state_q  <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (accept && is_digit) begin
            b_tens_q <= b_ones_q;
            b_ones_q <= key_code;
          end else if (accept && is_op) begin
            op_sub_q <= (key_code == KEY_SUB);
          end else if (accept && key_code == KEY_EQ) begin
            state_q     <= EXEC;
            key_ready_q <= 1'b0;
          end
        end
        EXEC: begin
          res_tens_q  <= res_tens_d;
          res_ones_q  <= res_ones_d;
          err_q       <= err_d;
          res_valid_q <= !err_d;
          state_q     <= err_d ? ERROR : SHOW;
          key_ready_q <= 1'b1;
        end
        SHOW, ERROR: begin
          // A fresh digit starts a new calculation from either terminal state.
          if (accept && is_digit) begin
            a_tens_q    <= '0;
            a_ones_q    <= key_code;
            b_tens_q    <= '0;
            b_ones_q    <= '0;
            res_tens_q  <= '0;
            res_ones_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= ENTER_A;
          end else if (accept && is_op && CHAIN_EN && state_q == SHOW) begin
            a_tens_q    <= res_tens_q;
            a_ones_q    <= res_ones_q;
            b_tens_q    <= '0;
            b_ones_q    <= '0;
            op_sub_q    <= (key_code == KEY_SUB);
            res_valid_q <= 1'b0;
            state_q     <= ENTER_B;
          end
        end
        default: state_q <= ENTER_A;
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign a_tens    = a_tens_q;
  assign a_ones    = a_ones_q;
  assign b_tens    = b_tens_q;
  assign b_ones    = b_ones_q;
  assign op_sub    = op_sub_q;
  assign res_tens  = res_tens_q;
  assign res_ones  = res_ones_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_bcd_calc_controller.sv
// Directed test of the BCD calculator controller; a second instance runs with chaining disabled.
module tb_bcd_calc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;

  logic       key_ready, op_sub, res_valid, err;
  logic [3:0] a_tens, a_ones, b_tens, b_ones, res_tens, res_ones;
  logic [2:0] state_o;

  logic       n_key_ready, n_op_sub, n_res_valid, n_err;
  logic [3:0] n_a_tens, n_a_ones, n_b_tens, n_b_ones, n_res_tens, n_res_ones;
  logic [2:0] n_state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_calc_controller #(.CHAIN_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .a_tens(a_tens), .a_ones(a_ones),
    .b_tens(b_tens), .b_ones(b_ones), .op_sub(op_sub),
    .res_tens(res_tens), .res_ones(res_ones), .res_valid(res_valid),
    .err(err), .state_o(state_o)
  );

  bcd_calc_controller #(.CHAIN_EN(1'b0)) dut_nochain (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(n_key_ready), .a_tens(n_a_tens), .a_ones(n_a_ones),
    .b_tens(n_b_tens), .b_ones(n_b_ones), .op_sub(n_op_sub),
    .res_tens(n_res_tens), .res_ones(n_res_ones), .res_valid(n_res_valid),
    .err(n_err), .state_o(n_state_o)
  );

  // Drives one key for a single rising edge; called and returns just after a falling edge.
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state_o); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b expected 1", key_ready); end
    checks++; if ({a_tens, a_ones, b_tens, b_ones} !== 16'h0000) begin errors++; $display("FAIL reset_operands got %h expected 0000", {a_tens, a_ones, b_tens, b_ones}); end
    checks++; if ({res_tens, res_ones} !== 8'h00) begin errors++; $display("FAIL reset_result got %h expected 00", {res_tens, res_ones}); end
    checks++; if ({op_sub, res_valid, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {op_sub, res_valid, err}); end
  endtask

  task automatic test_add();
    do_reset();
    press(4'd4); press(4'd7); press(4'd10); press(4'd3); press(4'd5);
    checks++; if ({a_tens, a_ones} !== 8'h47) begin errors++; $display("FAIL add_a got %h expected 47", {a_tens, a_ones}); end
    checks++; if ({b_tens, b_ones} !== 8'h35) begin errors++; $display("FAIL add_b got %h expected 35", {b_tens, b_ones}); end
    checks++; if (op_sub !== 1'b0) begin errors++; $display("FAIL add_op got %b expected 0", op_sub); end
    press(4'd12);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL add_exec_state got %0d expected 2", state_o); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready got %b expected 0", key_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid got %b expected 0", res_valid); end
    @(negedge clk);
    checks++; if ({res_tens, res_ones} !== 8'h82) begin errors++; $display("FAIL add_res got %h expected 82", {res_tens, res_ones}); end
    checks++; if ({res_valid, err, key_ready} !== 3'b101) begin errors++; $display("FAIL add_flags got %b expected 101", {res_valid, err, key_ready}); end
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL add_show_state got %0d expected 3", state_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    press(4'd6); press(4'd0); press(4'd10); press(4'd5); press(4'd5); press(4'd12);
    @(negedge clk);
    checks++; if ({err, res_valid} !== 2'b10) begin errors++; $display("FAIL ovf_flags got %b expected 10", {err, res_valid}); end
    checks++; if ({res_tens, res_ones} !== 8'h00) begin errors++; $display("FAIL ovf_res got %h expected 00", {res_tens, res_ones}); end
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL ovf_state got %0d expected 4", state_o); end
    press(4'd12);
    checks++; if ({state_o, err} !== 4'b1001) begin errors++; $display("FAIL ovf_eq_dropped got %b expected 1001", {state_o, err}); end
    press(4'd2);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_recover_err got %b expected 0", err); end
    checks++; if ({a_tens, a_ones} !== 8'h02) begin errors++; $display("FAIL ovf_recover_a got %h expected 02", {a_tens, a_ones}); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL ovf_recover_state got %0d expected 0", state_o); end
  endtask

  task automatic test_underflow();
    do_reset();
    press(4'd3); press(4'd0); press(4'd11); press(4'd4); press(4'd5); press(4'd12);
    @(negedge clk);
    checks++; if ({state_o, err, res_valid} !== 5'b10010) begin errors++; $display("FAIL udf_state_flags got %b expected 10010", {state_o, err, res_valid}); end
    press(4'd4); press(4'd5); press(4'd11); press(4'd0);
    checks++; if ({a_tens, a_ones, b_tens, b_ones} !== 16'h4500) begin errors++; $display("FAIL sub_zero_ops got %h expected 4500", {a_tens, a_ones, b_tens, b_ones}); end
    checks++; if (op_sub !== 1'b1) begin errors++; $display("FAIL sub_zero_op got %b expected 1", op_sub); end
    press(4'd12);
    @(negedge clk);
    checks++; if ({res_tens, res_ones} !== 8'h45) begin errors++; $display("FAIL sub_zero_res got %h expected 45", {res_tens, res_ones}); end
    checks++; if ({err, res_valid} !== 2'b01) begin errors++; $display("FAIL sub_zero_flags got %b expected 01", {err, res_valid}); end
  endtask

  task automatic test_chain();
    do_reset();
    press(4'd1); press(4'd2); press(4'd10); press(4'd3); press(4'd12);
    @(negedge clk);
    checks++; if ({res_tens, res_ones} !== 8'h15) begin errors++; $display("FAIL chain_first_res got %h expected 15", {res_tens, res_ones}); end
    checks++; if ({n_res_tens, n_res_ones, n_state_o} !== 11'b0001_0101_011) begin errors++; $display("FAIL nochain_first got %b expected 00010101011", {n_res_tens, n_res_ones, n_state_o}); end
    press(4'd11);
    checks++; if ({a_tens, a_ones, b_tens, b_ones} !== 16'h1500) begin errors++; $display("FAIL chain_ops got %h expected 1500", {a_tens, a_ones, b_tens, b_ones}); end
    checks++; if ({state_o, op_sub, res_valid} !== 5'b00110) begin errors++; $display("FAIL chain_state got %b expected 00110", {state_o, op_sub, res_valid}); end
    checks++; if ({n_state_o, n_op_sub, n_res_valid} !== 5'b01101) begin errors++; $display("FAIL nochain_op_dropped got %b expected 01101", {n_state_o, n_op_sub, n_res_valid}); end
    checks++; if ({n_a_tens, n_a_ones} !== 8'h12) begin errors++; $display("FAIL nochain_a got %h expected 12", {n_a_tens, n_a_ones}); end
    press(4'd0); press(4'd5); press(4'd12);
    @(negedge clk);
    checks++; if ({res_tens, res_ones, err} !== 9'b0001_0000_0) begin errors++; $display("FAIL chain_second_res got %b expected 000100000", {res_tens, res_ones, err}); end
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL chain_second_state got %0d expected 3", state_o); end
  endtask

  task automatic test_entry_shift();
    do_reset();
    press(4'd1); press(4'd2); press(4'd3);
    checks++; if ({a_tens, a_ones} !== 8'h23) begin errors++; $display("FAIL shift_a got %h expected 23", {a_tens, a_ones}); end
    press(4'd10); press(4'd7); press(4'd11);
    checks++; if ({state_o, op_sub} !== 4'b0011) begin errors++; $display("FAIL op_replace got %b expected 0011", {state_o, op_sub}); end
    checks++; if ({b_tens, b_ones} !== 8'h07) begin errors++; $display("FAIL op_replace_b got %h expected 07", {b_tens, b_ones}); end
    press(4'd15); press(4'd14);
    checks++; if ({state_o, op_sub, a_tens, a_ones, b_tens, b_ones} !== 20'h3_2307) begin errors++; $display("FAIL reserved_key got %h expected 32307", {state_o, op_sub, a_tens, a_ones, b_tens, b_ones}); end
    press(4'd13);
    checks++; if ({state_o, op_sub, a_tens, a_ones, b_tens, b_ones} !== 20'h0_0000) begin errors++; $display("FAIL clear got %h expected 00000", {state_o, op_sub, a_tens, a_ones, b_tens, b_ones}); end
  endtask

  task automatic test_exec_key();
    do_reset();
    press(4'd2); press(4'd10); press(4'd1); press(4'd12);
    press(4'd9);
    checks++; if ({a_tens, a_ones} !== 8'h02) begin errors++; $display("FAIL exec_key_a got %h expected 02", {a_tens, a_ones}); end
    checks++; if ({state_o, res_tens, res_ones} !== 11'b011_0000_0011) begin errors++; $display("FAIL exec_key_res got %b expected 01100000011", {state_o, res_tens, res_ones}); end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    press(4'd5); press(4'd10); press(4'd5); press(4'd12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({state_o, res_valid, err, key_ready} !== 6'b000001) begin errors++; $display("FAIL rst_exec_state got %b expected 000001", {state_o, res_valid, err, key_ready}); end
    checks++; if ({a_tens, a_ones, b_tens, b_ones, res_tens, res_ones} !== 24'h000000) begin errors++; $display("FAIL rst_exec_regs got %h expected 000000", {a_tens, a_ones, b_tens, b_ones, res_tens, res_ones}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_underflow();
    test_chain();
    test_entry_shift();
    test_exec_key();
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
